// File: rtl/hourglass_pkg.sv
// Shared definitions for the hourglass sand renderer.
//   state_t    : drain FSM states (IDLE, RUN, DONE)
//   DEF_W      : default coordinate width
//   DEF_RADIUS : default bulb radius in pixels
//   coord_t    : coordinate type at the default width
package hourglass_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEF_W      = 11;
    localparam int unsigned DEF_RADIUS = 100;

    typedef logic [DEF_W-1:0] coord_t;

endpackage

// File: rtl/hourglass_sand_bulb_disc.sv
// bulb_disc: two-stage "inside circle and at/below fill line" pixel test.
//   clk, BTN_S              : clock, synchronous active-high reset
//   centre_col, centre_row  : circle centre
//   fill_line               : signed row of the sand surface (may be negative)
//   visible_col/row         : current pixel
//   hit                     : registered result, two cycles after the pixel
module bulb_disc #(
    parameter int unsigned W      = hourglass_pkg::DEF_W,
    parameter int unsigned RADIUS = hourglass_pkg::DEF_RADIUS
) (
    input  logic                clk,
    input  logic                BTN_S,
    input  logic [W-1:0]        centre_col,
    input  logic [W-1:0]        centre_row,
    input  logic signed [W+1:0] fill_line,
    input  logic [W-1:0]        visible_col,
    input  logic [W-1:0]        visible_row,
    output logic                hit
);

    localparam int unsigned SQW = 2*W + 2;
    localparam logic [SQW:0] R_SQ = (SQW+1)'(RADIUS*RADIUS);

    logic signed [W:0]   dx_d, dy_d, dx_q, dy_q;
    logic                row_ok_d, row_ok_q;
    logic signed [SQW-1:0] dx_ext, dy_ext, sq_x, sq_y;
    logic [SQW:0]        sum_sq;

    assign dx_d     = $signed({1'b0, visible_col}) - $signed({1'b0, centre_col});
    assign dy_d     = $signed({1'b0, visible_row}) - $signed({1'b0, centre_row});
    assign row_ok_d = $signed({2'b00, visible_row}) >= fill_line;

    // Sign-extend before squaring so the full-width product is kept.
    assign dx_ext = SQW'(dx_q);
    assign dy_ext = SQW'(dy_q);
    assign sq_x   = dx_ext * dx_ext;
    assign sq_y   = dy_ext * dy_ext;
    assign sum_sq = {1'b0, sq_x} + {1'b0, sq_y};

    always_ff @(posedge clk) begin
        if (BTN_S) begin
            dx_q     <= '0;
            dy_q     <= '0;
            row_ok_q <= 1'b0;
            hit      <= 1'b0;
        end else begin
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            row_ok_q <= row_ok_d;
            hit      <= (sum_sq <= R_SQ) && row_ok_q;
        end
    end

endmodule

// File: rtl/hourglass_sand.sv
// hourglass_sand: sand renderer and drain controller for the hourglass display.
//   clk, BTN_S               : pixel clock, synchronous active-high reset
//   visible_col/row          : current scan position
//   ori_col, ori_row         : upper-bulb centre (lower centre is 2*RADIUS below)
//   frame_tick, start, flip  : one-cycle control pulses
//   sand_upper, sand_lower   : pixel shows sand (2-cycle pixel latency)
//   drained                  : rows moved to the lower bulb, 0..2*RADIUS
//   done                     : upper bulb empty
module hourglass_sand
    import hourglass_pkg::*;
#(
    parameter int unsigned W            = DEF_W,
    parameter int unsigned RADIUS       = DEF_RADIUS,
    parameter int unsigned DRAIN_FRAMES = 4
) (
    input  logic         clk,
    input  logic         BTN_S,
    input  logic [W-1:0] visible_col,
    input  logic [W-1:0] visible_row,
    input  logic [W-1:0] ori_col,
    input  logic [W-1:0] ori_row,
    input  logic         frame_tick,
    input  logic         start,
    input  logic         flip,
    output logic         sand_upper,
    output logic         sand_lower,
    output logic [W-1:0] drained,
    output logic         done
);

    localparam int unsigned CW = (DRAIN_FRAMES > 1) ? $clog2(DRAIN_FRAMES) : 1;
    localparam logic [W-1:0]  TWO_R   = W'(2*RADIUS);
    localparam logic [CW-1:0] CNT_TOP = CW'(DRAIN_FRAMES-1);

    state_t        state_q, state_n;
    logic [W-1:0]  drained_q, drained_n;
    logic [CW-1:0] cnt_q, cnt_n;

    always_ff @(posedge clk) begin
        if (BTN_S) begin
            state_q   <= IDLE;
            drained_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_n;
            drained_q <= drained_n;
            cnt_q     <= cnt_n;
        end
    end

    // Priority: flip over start over frame_tick; a tick alongside flip is dropped.
    always_comb begin
        state_n   = state_q;
        drained_n = drained_q;
        cnt_n     = cnt_q;
        if (flip) begin
            cnt_n = '0;
            if (state_q == IDLE) begin
                drained_n = TWO_R;
                state_n   = DONE;
            end else begin
                drained_n = TWO_R - drained_q;
                state_n   = (drained_n == TWO_R) ? DONE : RUN;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    drained_n = '0;
                    if (start) begin
                        state_n = RUN;
                        cnt_n   = '0;
                    end
                end
                RUN: begin
                    if (frame_tick) begin
                        if (cnt_q == CNT_TOP) begin
                            cnt_n     = '0;
                            drained_n = drained_q + 1'b1;
                            if (drained_n == TWO_R)
                                state_n = DONE;
                        end else begin
                            cnt_n = cnt_q + 1'b1;
                        end
                    end
                end
                DONE: ;
                default: state_n = IDLE;
            endcase
        end
    end

    assign drained = drained_q;
    assign done    = (state_q == DONE);

    // Fill lines use the drained value current at the sampling edge.
    logic signed [W+1:0] upper_fill, lower_fill;
    logic [W-1:0]        lower_centre_row;

    assign upper_fill = $signed({2'b00, ori_row}) - (W+2)'(RADIUS)
                      + $signed({2'b00, drained_q});
    assign lower_fill = $signed({2'b00, ori_row}) + (W+2)'(3*RADIUS)
                      - $signed({2'b00, drained_q});
    assign lower_centre_row = ori_row + TWO_R;

    bulb_disc #(.W(W), .RADIUS(RADIUS)) u_upper (
        .clk         (clk),
        .BTN_S       (BTN_S),
        .centre_col  (ori_col),
        .centre_row  (ori_row),
        .fill_line   (upper_fill),
        .visible_col (visible_col),
        .visible_row (visible_row),
        .hit         (sand_upper)
    );

    bulb_disc #(.W(W), .RADIUS(RADIUS)) u_lower (
        .clk         (clk),
        .BTN_S       (BTN_S),
        .centre_col  (ori_col),
        .centre_row  (lower_centre_row),
        .fill_line   (lower_fill),
        .visible_col (visible_col),
        .visible_row (visible_row),
        .hit         (sand_lower)
    );

endmodule

// File: tb/tb_hourglass_sand.sv
// Directed self-checking bench for hourglass_sand (RADIUS=100, DRAIN_FRAMES=2).
module tb_hourglass_sand;

    localparam int unsigned W = 11;

    logic         clk = 1'b0;
    logic         BTN_S;
    logic [W-1:0] visible_col, visible_row, ori_col, ori_row;
    logic         frame_tick, start, flip;
    logic         sand_upper, sand_lower, done;
    logic [W-1:0] drained;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    hourglass_sand #(.W(W), .RADIUS(100), .DRAIN_FRAMES(2)) dut (
        .clk         (clk),
        .BTN_S       (BTN_S),
        .visible_col (visible_col),
        .visible_row (visible_row),
        .ori_col     (ori_col),
        .ori_row     (ori_row),
        .frame_tick  (frame_tick),
        .start       (start),
        .flip        (flip),
        .sand_upper  (sand_upper),
        .sand_lower  (sand_lower),
        .drained     (drained),
        .done        (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step();
        end
        frame_tick = 1'b0;
    endtask

    // Present a pixel and wait out the two-stage pipeline.
    task automatic pixel(input int unsigned col, input int unsigned row);
        visible_col = W'(col);
        visible_row = W'(row);
        step();
        step();
    endtask

    initial begin
        BTN_S = 1'b1; frame_tick = 1'b0; start = 1'b0; flip = 1'b0;
        ori_col = W'(320); ori_row = W'(120);
        visible_col = W'(320); visible_row = W'(120);
        step(); step();
        check_eq("rst_drained", 32'(drained), 0);
        check_eq("rst_done",    32'(done), 0);
        check_eq("rst_upper",   32'(sand_upper), 0);
        check_eq("rst_lower",   32'(sand_lower), 0);
        BTN_S = 1'b0;

        // Idle geometry (drained = 0: upper full, lower empty)
        pixel(320, 120);
        check_eq("idle_centre_upper", 32'(sand_upper), 1);
        check_eq("idle_centre_lower", 32'(sand_lower), 0);
        pixel(320, 320);
        check_eq("idle_lowc_lower", 32'(sand_lower), 0);
        check_eq("idle_lowc_upper", 32'(sand_upper), 0);
        pixel(421, 120);
        check_eq("outside_upper", 32'(sand_upper), 0);
        check_eq("outside_lower", 32'(sand_lower), 0);
        pixel(320, 20);
        check_eq("edge_top_in", 32'(sand_upper), 1);
        pixel(320, 19);
        check_eq("edge_top_out", 32'(sand_upper), 0);
        pixel(320, 420);
        check_eq("edge_bottom_lower", 32'(sand_lower), 1);

        // Drain
        start = 1'b1; step(); start = 1'b0;
        check_eq("start_drained", 32'(drained), 0);
        ticks(4);
        check_eq("drain4", 32'(drained), 2);
        check_eq("drain4_done", 32'(done), 0);
        pixel(320, 21);
        check_eq("fill22_above", 32'(sand_upper), 0);
        pixel(320, 22);
        check_eq("fill22_on", 32'(sand_upper), 1);
        ticks(396);
        check_eq("drain400", 32'(drained), 200);
        check_eq("drain400_done", 32'(done), 1);
        ticks(1);
        check_eq("done_hold", 32'(drained), 200);
        pixel(320, 320);
        check_eq("full_lower", 32'(sand_lower), 1);
        pixel(320, 120);
        check_eq("empty_upper", 32'(sand_upper), 0);

        // Flip when done
        flip = 1'b1; step(); flip = 1'b0;
        check_eq("flipdone_drained", 32'(drained), 0);
        check_eq("flipdone_done", 32'(done), 0);
        ticks(60);
        check_eq("drain30", 32'(drained), 30);

        // Flip mid-drain, then flip with a simultaneous tick
        flip = 1'b1; step(); flip = 1'b0;
        check_eq("flip30", 32'(drained), 170);
        check_eq("flip30_done", 32'(done), 0);
        flip = 1'b1; frame_tick = 1'b1; step(); flip = 1'b0; frame_tick = 1'b0;
        check_eq("fliptick", 32'(drained), 30);
        ticks(1);
        check_eq("cnt_cleared_t1", 32'(drained), 30);
        ticks(1);
        check_eq("cnt_cleared_t2", 32'(drained), 31);
        start = 1'b1; step(); start = 1'b0;
        check_eq("start_in_run", 32'(drained), 31);
        ticks(52);
        check_eq("drain57", 32'(drained), 57);

        // Mid-run reset
        pixel(320, 120);
        check_eq("pre_rst_upper", 32'(sand_upper), 1);
        BTN_S = 1'b1; step(); BTN_S = 1'b0;
        check_eq("midrst_drained", 32'(drained), 0);
        check_eq("midrst_done", 32'(done), 0);
        check_eq("midrst_upper", 32'(sand_upper), 0);
        check_eq("midrst_lower", 32'(sand_lower), 0);
        ticks(2);
        check_eq("idle_tick", 32'(drained), 0);

        // Flip in IDLE, start ignored in DONE
        flip = 1'b1; step(); flip = 1'b0;
        check_eq("flipidle_drained", 32'(drained), 200);
        check_eq("flipidle_done", 32'(done), 1);
        start = 1'b1; step(); start = 1'b0;
        check_eq("start_in_done", 32'(drained), 200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
